// File: rtl/lcd_spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_master_pkg
// Description : Shared definitions for the LCD SPI transmit engine: FSM state
//               encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_spi_master_pkg;

    localparam int C_DEF_DATA_W     = 8;
    localparam int C_DEF_FIFO_DEPTH = 16;
    localparam int C_DEF_DIV_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // chip select high, waiting for a word
        ST_CSSU  = 3'd1,   // chip-select setup, first bit presented
        ST_SHIFT = 3'd2,   // serialising bit cells
        ST_LOAD  = 3'd3,   // one-cycle reload between back-to-back frames
        ST_CSHD  = 3'd4    // chip-select hold before release
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_fifo
// Description : Synchronous write FIFO with occupancy count. Pushes into a
//               full FIFO are refused even when a pop happens in the same
//               cycle; pops are ignored while empty.
// Ports       : clk_i, rst_ni (async, active-low)
//               push_i/wdata_i  - write side
//               pop_i/rdata_o   - read side (rdata_o is the head entry)
//               full_o          - FIFO full
//               level_o         - registered occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + PTR_W'(1);
            if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_master
// Description : SPI transmit engine for the display path. Words {dc, data}
//               are queued in a write FIFO and serialised on sda_o/scl_o with
//               a runtime divider, CPOL/CPHA modes and selectable bit order.
//               Chip select is held low across back-to-back frames.
// Ports       : clk_i, rst_ni (async, active-low)
//               wvalid_i/wready_o/wdata_i/wdc_i - FIFO write interface
//               div_i, cpol_i, cpha_i, lsb_first_i - burst configuration
//               sda_o, scl_o, dc_o, cs_no - serial interface
//               busy_o, level_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_master
    import lcd_spi_master_pkg::*;
#(
    parameter int DATA_W     = C_DEF_DATA_W,
    parameter int FIFO_DEPTH = C_DEF_FIFO_DEPTH,
    parameter int DIV_W      = C_DEF_DIV_W,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wdc_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    output logic              sda_o,
    output logic              scl_o,
    output logic              dc_o,
    output logic              cs_no,
    output logic              busy_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam int CNT_W = DIV_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                half_q, half_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                dc_q, dc_d;
    logic                cs_n_q, cs_n_d;
    logic                scl_q, scl_d;
    logic                sda_q, sda_d;
    logic                busy_q, busy_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;

    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_nonempty;
    logic                w_nonempty_next;
    logic [DATA_W:0]     w_head;
    logic [CNT_W-1:0]    w_reload;
    logic                w_scl_first;

    lcd_spi_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wvalid_i),
        .wdata_i ({wdc_i, wdata_i}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .level_o (level_o)
    );

    assign wready_o   = !w_full;
    assign w_push     = wvalid_i && !w_full;
    assign w_nonempty = (level_o != '0);
    assign w_reload   = {1'b0, div_q};
    // SCL level during the first half of a bit cell: CPOL for CPHA=0,
    // the active level for CPHA=1.
    assign w_scl_first = cpol_q ^ cpha_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        dc_d    = dc_q;
        cs_n_d  = cs_n_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        div_d   = div_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                scl_d  = cpol_i;
                sda_d  = 1'b0;
                if (w_nonempty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_head[DATA_W-1:0];
                    dc_d    = w_head[DATA_W];
                    div_d   = div_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_first_i;
                    cs_n_d  = 1'b0;
                    sda_d   = lsb_first_i ? w_head[0] : w_head[DATA_W-1];
                    cnt_d   = {1'b0, div_i};
                    state_d = ST_CSSU;
                end
            end
            ST_CSSU: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = w_reload;
                    bit_d   = '0;
                    half_d  = 1'b0;
                    scl_d   = w_scl_first;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!half_q) begin
                    cnt_d  = w_reload;
                    half_d = 1'b1;
                    scl_d  = !w_scl_first;
                end else if (bit_q != BIT_W'(DATA_W - 1)) begin
                    cnt_d   = w_reload;
                    half_d  = 1'b0;
                    bit_d   = bit_q + BIT_W'(1);
                    scl_d   = w_scl_first;
                    shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
                    sda_d   = lsb_q ? shreg_q[1] : shreg_q[DATA_W-2];
                end else if (w_nonempty) begin
                    // Back-to-back frame: reload without releasing CS.
                    w_pop   = 1'b1;
                    shreg_d = w_head[DATA_W-1:0];
                    dc_d    = w_head[DATA_W];
                    sda_d   = lsb_q ? w_head[0] : w_head[DATA_W-1];
                    scl_d   = cpol_q;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d   = w_reload;
                    scl_d   = cpol_q;
                    state_d = ST_CSHD;
                end
            end
            ST_LOAD: begin
                cnt_d   = w_reload;
                bit_d   = '0;
                half_d  = 1'b0;
                scl_d   = w_scl_first;
                state_d = ST_SHIFT;
            end
            ST_CSHD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cs_n_d  = 1'b1;
                    scl_d   = cpol_i;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Occupancy after this cycle's push/pop decides the next busy value.
        w_nonempty_next = w_push || (level_o > LVL_W'(1)) ||
                          ((level_o == LVL_W'(1)) && !w_pop);
        busy_d = w_nonempty_next || !cs_n_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            shreg_q <= '0;
            dc_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b0;
            busy_q  <= 1'b0;
            div_q   <= '0;
            cpol_q  <= 1'b1;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            dc_q    <= dc_d;
            cs_n_q  <= cs_n_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
        end
    end

    assign sda_o  = sda_q;
    assign scl_o  = scl_q;
    assign dc_o   = dc_q;
    assign cs_no  = cs_n_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_master
// Description : Directed self-checking bench for lcd_spi_master. A line
//               monitor decodes frames from sda/scl using the intended mode
//               and records chip-select window statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_master;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 8;
    localparam int LVL_W      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [DATA_W-1:0] wdata = '0;
    logic              wdc = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic              cpol = 1'b1;
    logic              cpha = 1'b0;
    logic              lsb = 1'b0;
    logic              sda, scl, dc, cs_n, busy;
    logic [LVL_W-1:0]  level;

    always #5 clk = ~clk;

    lcd_spi_master #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .LVL_W      (LVL_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wvalid_i    (wvalid),
        .wready_o    (wready),
        .wdata_i     (wdata),
        .wdc_i       (wdc),
        .div_i       (div),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .lsb_first_i (lsb),
        .sda_o       (sda),
        .scl_o       (scl),
        .dc_o        (dc),
        .cs_no       (cs_n),
        .busy_o      (busy),
        .level_o     (level)
    );

    int checks   = 0;
    int failures = 0;

    // Mode the bench expects the current burst to use.
    logic m_cpol = 1'b1;
    logic m_cpha = 1'b0;
    logic m_lsb  = 1'b0;

    int win_cnt   = 0;
    int win_len   = 0;
    int win_lead  = 0;
    int win_first = 0;
    int win_hi    = 0;
    logic [7:0] rx_q [$];
    logic       rx_dc_q [$];

    // Line monitor: one step per clock, sampled on the falling edge.
    initial begin
        logic       prev_scl;
        logic       lead;
        logic [7:0] rx_sh;
        int         k, lead_cnt, first_lead, sda_hi, rx_n;
        prev_scl = 1'b1;
        rx_sh = '0;
        k = 0; lead_cnt = 0; first_lead = 0; sda_hi = 0; rx_n = 0;
        forever begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                k++;
                if (sda === 1'b1) sda_hi++;
                if (scl !== prev_scl) begin
                    lead = (scl !== m_cpol);
                    if (lead) begin
                        lead_cnt++;
                        if (first_lead == 0) first_lead = k;
                    end
                    if (lead != m_cpha) begin
                        rx_sh = m_lsb ? {sda, rx_sh[7:1]} : {rx_sh[6:0], sda};
                        rx_n++;
                        if (rx_n == 8) begin
                            rx_q.push_back(rx_sh);
                            rx_dc_q.push_back(dc);
                            rx_n = 0;
                        end
                    end
                end
            end else if (k != 0) begin
                win_len   = k;
                win_lead  = lead_cnt;
                win_first = first_lead;
                win_hi    = sda_hi;
                win_cnt++;
                k = 0; lead_cnt = 0; first_lead = 0; sda_hi = 0; rx_n = 0;
            end
            prev_scl = scl;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d_c, input logic [7:0] d);
        wvalid = 1'b1;
        wdc    = d_c;
        wdata  = d;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input int target, input int budget);
        int n;
        n = 0;
        while (win_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("window_done", 32'(win_cnt), 32'(target));
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] d, input logic d_c);
        logic [7:0] od;
        logic       odc;
        if (rx_q.size() > 0) begin
            od  = rx_q.pop_front();
            odc = rx_dc_q.pop_front();
        end else begin
            od  = 'x;
            odc = 1'bx;
        end
        check({tag, "_data"}, 32'(od), 32'(d));
        check({tag, "_dc"}, 32'(odc), 32'(d_c));
    endtask

    initial begin
        int w;

        // ---------------- reset state ----------------
        cycles(3);
        check("rst_cs_n",  32'(cs_n),  32'h1);
        check("rst_scl",   32'(scl),   32'h1);
        check("rst_sda",   32'(sda),   32'h0);
        check("rst_dc",    32'(dc),    32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_level", 32'(level), 32'h0);
        rst_n = 1'b1;
        cycles(1);
        check("rel_wready", 32'(wready), 32'h1);

        // ---------------- 1: div0, mode 3, MSB first ----------------
        div = 8'd0; cpol = 1'b1; cpha = 1'b1; lsb = 1'b0;
        m_cpol = 1'b1; m_cpha = 1'b1; m_lsb = 1'b0;
        cycles(2);
        w = win_cnt;
        push(1'b1, 8'hA5);
        check("t1_busy_after_push", 32'(busy), 32'h1);
        wait_win(w + 1, 200);
        check("t1_window",     32'(win_len),   32'd18);
        check("t1_lead_edges", 32'(win_lead),  32'd8);
        check("t1_first_lead", 32'(win_first), 32'd2);
        check("t1_sda_high",   32'(win_hi),    32'd10);
        check("t1_busy_end",   32'(busy),      32'h0);
        check("t1_cs_end",     32'(cs_n),      32'h1);
        expect_rx("t1", 8'hA5, 1'b1);

        // ---------------- 2: div3, mode 0, LSB first ----------------
        div = 8'd3; cpol = 1'b0; cpha = 1'b0; lsb = 1'b1;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b1;
        cycles(2);
        check("t2_idle_scl", 32'(scl), 32'h0);
        w = win_cnt;
        push(1'b0, 8'h01);
        wait_win(w + 1, 400);
        check("t2_window",     32'(win_len),   32'd72);
        check("t2_lead_edges", 32'(win_lead),  32'd8);
        check("t2_first_lead", 32'(win_first), 32'd9);
        check("t2_sda_high",   32'(win_hi),    32'd12);
        expect_rx("t2", 8'h01, 1'b0);

        // ---------------- 3: three back-to-back frames ----------------
        div = 8'd0; cpol = 1'b1; cpha = 1'b1; lsb = 1'b0;
        m_cpol = 1'b1; m_cpha = 1'b1; m_lsb = 1'b0;
        cycles(2);
        w = win_cnt;
        push(1'b1, 8'h11);
        push(1'b0, 8'h22);
        push(1'b1, 8'h33);
        check("t3_level_a", 32'(level), 32'd2);
        cycles(20);
        check("t3_level_b", 32'(level), 32'd1);
        cycles(20);
        check("t3_level_c", 32'(level), 32'd0);
        wait_win(w + 1, 400);
        check("t3_window",     32'(win_len),  32'd52);
        check("t3_lead_edges", 32'(win_lead), 32'd24);
        expect_rx("t3_f0", 8'h11, 1'b1);
        expect_rx("t3_f1", 8'h22, 1'b0);
        expect_rx("t3_f2", 8'h33, 1'b1);

        // ---------------- 5: config change mid-burst ----------------
        div = 8'd1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        cycles(2);
        w = win_cnt;
        push(1'b1, 8'hC3);
        push(1'b0, 8'h3C);
        cycles(10);
        cpol = 1'b1;
        div  = 8'd0;
        wait_win(w + 1, 400);
        check("t5_window", 32'(win_len), 32'd69);
        expect_rx("t5_f0", 8'hC3, 1'b1);
        expect_rx("t5_f1", 8'h3C, 1'b0);
        m_cpol = 1'b1;
        cycles(2);
        check("t5_idle_scl", 32'(scl), 32'h1);
        w = win_cnt;
        push(1'b0, 8'h96);
        wait_win(w + 1, 200);
        check("t5_new_window",     32'(win_len),   32'd18);
        check("t5_new_first_lead", 32'(win_first), 32'd3);
        expect_rx("t5_new", 8'h96, 1'b0);

        // ---------------- 4: overflow with a stalled engine ----------------
        div = 8'd255; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        cycles(2);
        push(1'b1, 8'h5A);
        for (int i = 0; i < 16; i++) push(1'b1, 8'(8'h80 + i));
        check("t4_level_full",  32'(level),  32'd16);
        check("t4_wready_full", 32'(wready), 32'h0);
        push(1'b1, 8'h90);
        check("t4_level_refused", 32'(level), 32'd16);
        check("t4_busy",          32'(busy),  32'h1);

        // ---------------- 6: reset mid-SHIFT ----------------
        cycles(300);
        check("t6_cs_before", 32'(cs_n), 32'h0);
        w = win_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_async_cs",    32'(cs_n),  32'h1);
        check("t6_async_scl",   32'(scl),   32'h1);
        check("t6_async_sda",   32'(sda),   32'h0);
        check("t6_async_busy",  32'(busy),  32'h0);
        check("t6_async_level", 32'(level), 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(10);
        check("t6_no_residual_cs",   32'(cs_n),        32'h1);
        check("t6_no_residual_busy", 32'(busy),        32'h0);
        check("t6_level_cleared",    32'(level),       32'd0);
        check("t6_rx_empty",         32'(rx_q.size()), 32'd0);
        div = 8'd0; cpol = 1'b1; cpha = 1'b1; lsb = 1'b0;
        m_cpol = 1'b1; m_cpha = 1'b1; m_lsb = 1'b0;
        cycles(2);
        w = win_cnt;
        push(1'b1, 8'h3C);
        wait_win(w + 1, 200);
        check("t6_window", 32'(win_len), 32'd18);
        expect_rx("t6", 8'h3C, 1'b1);
        check("t6_rx_drained", 32'(rx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
